// File: rtl/load_store_unit_if.sv
//------------------------------------------------------------------------------
// Module      : load_store_unit_if
// Description : Core-side request/response and memory-port bundle for the LSU.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module      : load_store_unit
// Description : RV32I load/store unit; sub-word stores done as read-modify-write.
//               Define LSU_ALIGN_CHECK_EN to flag misaligned accesses as errors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int WORD_SHIFT = 2
) (
  input  wire logic         CLK,
  input  wire logic         rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        req_err;
  logic [31:0] addr_eff;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    if (bus.req_we) begin
      illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    end else begin
      illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
    end
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    addr_eff = bus.req_addr;
`ifdef LSU_ALIGN_CHECK_EN
    req_err = illegal || misaligned;
`else
    // Misalignment is silently fixed by rounding down to natural alignment.
    req_err = illegal;
    if (bus.req_funct3[1:0] == 2'b01) begin
      addr_eff[0] = 1'b0;
    end
    if (bus.req_funct3[1:0] == 2'b10) begin
      addr_eff[1:0] = 2'b00;
    end
`endif
  end

  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = bus.mem_rd[7:0];
      2'd1:    rd_byte = bus.mem_rd[15:8];
      2'd2:    rd_byte = bus.mem_rd[23:16];
      default: rd_byte = bus.mem_rd[31:24];
    endcase
    rd_half = lane_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    case (f3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = bus.mem_rd;
    endcase

    merged = bus.mem_rd;
    if (f3_q[1:0] == 2'b00) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    mem_a_d  = mem_a_q;
    mem_wd_d = mem_wd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          lane_d  = addr_eff[1:0];
          wdata_d = bus.req_wdata[15:0];
          err_d   = req_err;
          rdata_d = 32'd0;
          if (req_err) begin
            state_d = S_RESP;
          end else begin
            mem_a_d = addr_eff >> WORD_SHIFT;
            if (bus.req_we && (bus.req_funct3[1:0] == 2'b10)) begin
              mem_wd_d = bus.req_wdata;
              state_d  = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: begin
        if (we_q) begin
          mem_wd_d = merged;
          state_d  = S_WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      lane_q   <= 2'd0;
      wdata_q  <= 16'd0;
      mem_a_q  <= 32'd0;
      mem_wd_q <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      lane_q   <= lane_d;
      wdata_q  <= wdata_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Gating with rst keeps the unit from advertising readiness during reset.
  assign bus.req_ready = (state_q == S_IDLE) && !rst;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_wd    = mem_wd_q;

endmodule

`default_nettype wire
